// File: rtl/cic_comp_pkg.sv
// Shared constants and types for the CIC compensation decimator.
// Coefficients are symmetric, sum to 64, so a >>6 gives unity DC gain.
package cic_comp_pkg;

  localparam int NTAPS    = 8;
  localparam int ROUND_SH = 6;
  localparam int COEF_W   = 6;

  localparam logic signed [COEF_W-1:0] COEF [NTAPS] = '{
    -6'sd1, -6'sd2, 6'sd6, 6'sd29, 6'sd29, 6'sd6, -6'sd2, -6'sd1
  };

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    RND,
    OUT
  } comp_state_t;

endpackage

// File: rtl/cic_comp_decim2_sat_round.sv
// Round-half-up by 2^ROUND_SH then clamp to the signed OUT_W range.
// Combinational, no latency; no flow control.
module sat_round import cic_comp_pkg::*; #(
  parameter int ACC_W = 23,
  parameter int OUT_W = 16
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] res
);

  localparam int SW = ACC_W + 1 - ROUND_SH;
  localparam logic [ACC_W:0] HALF = (ACC_W + 1)'(1) << (ROUND_SH - 1);

  logic [SW-1:0] shifted;
  logic          in_range;

  // One guard bit so adding the half-LSB can never wrap.
  assign shifted  = SW'(($signed({acc[ACC_W-1], acc}) + $signed(HALF)) >>> ROUND_SH);
  assign in_range = (&shifted[SW-1:OUT_W-1]) | ~(|shifted[SW-1:OUT_W-1]);

  always_comb begin
    res = shifted[OUT_W-1:0];
    if (!in_range) begin
      res = shifted[SW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/cic_comp_decim2.sv
// Decimate-by-2 8-tap compensation FIR with a serial MAC; trigger in T -> out_valid in T+10.
// Output held until out_ready; inputs arriving while busy are dropped and flag overrun.
module cic_comp_decim2 import cic_comp_pkg::*; #(
  parameter int IN_W  = 14,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  input  logic             clr_ovr
);

  localparam int ACC_W = IN_W + 9;
  localparam int K_W   = $clog2(NTAPS);
  localparam logic [K_W-1:0] K_LAST = K_W'(NTAPS - 1);

  comp_state_t             state, state_nxt;
  logic signed [IN_W-1:0]  x_dat [NTAPS];
  logic signed [IN_W-1:0]  samp;
  logic                    phase;
  logic [K_W-1:0]          k;
  logic signed [ACC_W-1:0] acc, prod;
  logic signed [OUT_W-1:0] rnd_dat;
  logic                    accept, trig, out_hs, start, ovr_set;

  // Offset binary to two's complement is just an MSB flip.
  assign samp    = {~in_data[IN_W-1], in_data[IN_W-2:0]};
  assign accept  = in_valid && (state == IDLE || state == OUT);
  assign trig    = accept && phase;
  assign out_hs  = out_valid && out_ready;
  assign ovr_set = (in_valid && !accept) || (trig && state == OUT && !out_hs);
  assign prod    = ACC_W'(COEF[k]) * ACC_W'(x_dat[k]);

  sat_round #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_sat_round (
    .acc (acc),
    .res (rnd_dat)
  );

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (trig) begin
          state_nxt = MAC;
          start     = 1'b1;
        end
      end
      MAC: if (k == K_LAST) state_nxt = RND;
      RND: state_nxt = OUT;
      OUT: begin
        // A trigger while the result is still held only pushes the sample.
        if (out_hs) begin
          if (trig) begin
            state_nxt = MAC;
            start     = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= 1'b0;
      k         <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < NTAPS; i++) x_dat[i] <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        for (int i = NTAPS - 1; i > 0; i--) x_dat[i] <= x_dat[i-1];
        x_dat[0] <= samp;
        phase    <= ~phase;
      end
      if (start) begin
        k   <= '0;
        acc <= '0;
      end else if (state == MAC) begin
        acc <= acc + prod;
        k   <= k + 1'b1;
      end
      if (state == RND) begin
        out_data  <= rnd_dat;
        out_valid <= 1'b1;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
      if (ovr_set) overrun <= 1'b1;
      else if (clr_ovr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cic_comp_decim2.sv
// Bench for cic_comp_decim2: 16-bit and 14-bit output instances share stimulus and are
// checked every cycle against a cycle-count reference model, plus directed expectations.
module tb_cic_comp_decim2;

  logic        clk = 1'b0;
  logic        reset, in_valid, out_ready, clr_ovr;
  logic [13:0] in_data;
  logic [15:0] out_data16;
  logic [13:0] out_data14;
  logic        out_valid16, out_valid14, overrun16, overrun14;

  always #5 clk = ~clk;

  cic_comp_decim2 #(.IN_W(14), .OUT_W(16)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data16), .out_valid(out_valid16), .out_ready(out_ready),
    .overrun(overrun16), .clr_ovr(clr_ovr)
  );

  cic_comp_decim2 #(.IN_W(14), .OUT_W(14)) dut14 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data14), .out_valid(out_valid14), .out_ready(out_ready),
    .overrun(overrun14), .clr_ovr(clr_ovr)
  );

  localparam int COEF_M [8] = '{-1, -2, 6, 29, 29, 6, -2, -1};

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model state: sample history (newest first) and timing of the pending result.
  int     hist [8];
  bit     phase_m, pend, ovr_m, chk_en;
  longint cyc, valid_from, busy_end;
  int     exp16, exp14, cur16, cur14;
  int     obs16_q[$], obs14_q[$];
  bit     rdy_g;

  function automatic int round_sat(input longint a, input int ow);
    longint num, r, hi, lo;
    num = a + 32;
    r = num / 64;
    if (num < 0 && (num % 64) != 0) r = r - 1;
    hi = (longint'(1) << (ow - 1)) - 1;
    lo = -hi - 1;
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return int'(r);
  endfunction

  function automatic int ref_fir(input int s[8], input int ow);
    longint a = 0;
    for (int i = 0; i < 8; i++) a += longint'(COEF_M[i]) * s[i];
    return round_sat(a, ow);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 8; i++) hist[i] = 0;
    phase_m = 0; pend = 0; ovr_m = 0;
    valid_from = 0; busy_end = -1;
    exp16 = 0; exp14 = 0; cur16 = 0; cur14 = 0;
  endfunction

  function automatic void model_update(input bit rst, input bit vld, input int dat,
                                       input bit rdy, input bit clr);
    bit vis, hs, set, started;
    if (rst) begin
      model_clear();
      return;
    end
    vis = pend && (cyc >= valid_from);
    hs = vis && rdy;
    set = 0;
    started = 0;
    if (vld) begin
      if (cyc <= busy_end) set = 1;
      else begin
        for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = dat - 8192;
        if (phase_m) begin
          if (vis && !hs) set = 1;
          else begin
            exp16 = ref_fir(hist, 16);
            exp14 = ref_fir(hist, 14);
            pend = 1;
            valid_from = cyc + 10;
            busy_end = cyc + 9;
            started = 1;
          end
        end
        phase_m = !phase_m;
      end
    end
    if (hs && !started) pend = 0;
    if (set) ovr_m = 1;
    else if (clr) ovr_m = 0;
  endfunction

  task automatic step(input bit rst, input bit vld, input int dat, input bit rdy, input bit clr);
    bit vis;
    int o16, o14;
    @(negedge clk);
    vis = pend && (cyc >= valid_from);
    if (vis) begin
      cur16 = exp16;
      cur14 = exp14;
    end
    o16 = int'($signed(out_data16));
    o14 = int'($signed(out_data14));
    if (chk_en) begin
      check_val("out_valid16", out_valid16, vis);
      check_val("out_valid14", out_valid14, vis);
      check_val("out_data16", o16, cur16);
      check_val("out_data14", o14, cur14);
      check_val("overrun16", overrun16, ovr_m);
      check_val("overrun14", overrun14, ovr_m);
    end
    if (out_valid16 && rdy) obs16_q.push_back(o16);
    if (out_valid14 && rdy) obs14_q.push_back(o14);
    reset = rst; in_valid = vld; in_data = 14'(dat); out_ready = rdy; clr_ovr = clr;
    model_update(rst, vld, dat, rdy, clr);
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, int'($urandom_range(0, 16383)), rdy_g, 0);
  endtask

  task automatic send(input int dat, input int gap);
    step(0, 1, dat, rdy_g, 0);
    idle(gap - 1);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int imp_exp[6];
    int sat_codes[8];
    int s[6], h[8], held, n0, exp_v;

    reset = 1; in_valid = 0; in_data = '0; out_ready = 1; clr_ovr = 0;
    cyc = 0; chk_en = 0; rdy_g = 1;
    model_clear();
    do_reset();
    chk_en = 1;
    do_reset();
    idle(3);

    // Impulse: +64 as the second sample, zeros around it.
    imp_exp = '{-1, 6, 29, -2, 0, 0};
    obs16_q.delete();
    send(14'h2000, 20);
    send(14'h2040, 20);
    repeat (10) send(14'h2000, 20);
    check_val("impulse_count", obs16_q.size(), 6);
    for (int i = 0; i < 6; i++)
      check_val($sformatf("impulse_%0d", i), (i < obs16_q.size()) ? obs16_q[i] : 99999, imp_exp[i]);

    // DC levels, both rails.
    do_reset();
    obs16_q.delete(); obs14_q.delete();
    repeat (16) send(14'h3FFF, 12);
    check_val("dc_pos16", obs16_q.size() > 0 ? obs16_q[$] : 99999, 8191);
    check_val("dc_pos14", obs14_q.size() > 0 ? obs14_q[$] : 99999, 8191);
    repeat (16) send(14'h0000, 12);
    check_val("dc_neg16", obs16_q.size() > 0 ? obs16_q[$] : 99999, -8192);
    check_val("dc_neg14", obs14_q.size() > 0 ? obs14_q[$] : 99999, -8192);

    // Saturation: raw 9727 fits 16 bits, clamps to 8191 at 14 bits.
    do_reset();
    obs16_q.delete(); obs14_q.delete();
    sat_codes = '{14'h0000, 14'h0000, 14'h3FFF, 14'h3FFF, 14'h3FFF, 14'h3FFF, 14'h0000, 14'h0000};
    for (int i = 0; i < 8; i++) send(sat_codes[i], 12);
    check_val("sat16", obs16_q.size() > 0 ? obs16_q[$] : 99999, 9727);
    check_val("sat14", obs14_q.size() > 0 ? obs14_q[$] : 99999, 8191);

    // Backpressure across the next trigger.
    do_reset();
    for (int i = 0; i < 6; i++) s[i] = int'($urandom_range(0, 16383));
    rdy_g = 0;
    send(s[0], 12);
    send(s[1], 14);
    h = '{s[1] - 8192, s[0] - 8192, 0, 0, 0, 0, 0, 0};
    held = ref_fir(h, 16);
    check_val("bp_valid_before", out_valid16, 1);
    check_val("bp_data_before", int'($signed(out_data16)), held);
    send(s[2], 12);
    send(s[3], 12);
    check_val("bp_overrun", overrun16, 1);
    check_val("bp_hold", int'($signed(out_data16)), held);
    check_val("bp_valid_hold", out_valid16, 1);
    rdy_g = 1;
    obs16_q.delete();
    idle(2);
    send(s[4], 12);
    send(s[5], 12);
    h = '{s[5] - 8192, s[4] - 8192, s[3] - 8192, s[2] - 8192, s[1] - 8192, s[0] - 8192, 0, 0};
    exp_v = ref_fir(h, 16);
    check_val("bp_after", obs16_q.size() > 0 ? obs16_q[$] : 99999, exp_v);
    step(0, 0, 0, 1, 1);
    idle(1);
    check_val("clr_ovr", overrun16, 0);

    // Drop in MAC: sample 3 cycles after the trigger is lost, result unaffected.
    do_reset();
    obs16_q.delete();
    send(14'h2000, 20);
    step(0, 1, 14'h2040, 1, 0);
    idle(2);
    step(0, 1, int'($urandom_range(0, 16383)), 1, 0);
    idle(20);
    check_val("mac_drop_result", obs16_q.size() > 0 ? obs16_q[$] : 99999, -1);
    check_val("mac_drop_overrun", overrun16, 1);

    // Reset in the middle of MAC clears outputs and restarts the pairing.
    send(14'h2100, 20);
    step(0, 1, 14'h2200, 1, 0);
    idle(1);
    step(0, 1, 14'h2300, 1, 0);
    idle(1);
    step(1, 0, 0, 1, 0);
    idle(1);
    check_val("rst_valid", out_valid16, 0);
    check_val("rst_data", int'($signed(out_data16)), 0);
    check_val("rst_overrun", overrun16, 0);
    n0 = obs16_q.size();
    send(int'($urandom_range(0, 16383)), 15);
    check_val("rst_one_sample", obs16_q.size(), n0);
    send(int'($urandom_range(0, 16383)), 12);
    check_val("rst_two_samples", obs16_q.size(), n0 + 1);

    // Random traffic: dense and sparse inputs, random ready, occasional clear and reset.
    for (int i = 0; i < 4000; i++) begin
      int code;
      case ($urandom_range(0, 3))
        0: code = 0;
        1: code = 16383;
        default: code = int'($urandom_range(0, 16383));
      endcase
      step(($urandom_range(0, 599) == 0), ($urandom_range(0, 5) == 0), code,
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0));
    end
    idle(15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
